// File: rtl/mdu_pkg.sv
// mdu_pkg: op and state encodings, MUL_LAT bounds and sign helper shared by the multiply unit.
package mdu_pkg;
   localparam logic [1:0] MDU_MULTU = 2'b00;
   localparam logic [1:0] MDU_MULT  = 2'b01;
   localparam logic [1:0] MDU_MTHI  = 2'b10;
   localparam logic [1:0] MDU_MTLO  = 2'b11;
   localparam int MUL_LAT_MIN = 1;
   localparam int MUL_LAT_MAX = 15;
   localparam int CNT_W       = 4;
   typedef enum logic {MDU_IDLE = 1'b0, MDU_CALC = 1'b1} mdu_state_e;
   // 0x80000000 negates to itself, which is the correct unsigned magnitude
   function automatic logic [31:0] mag(input logic [31:0] v);
      return v[31] ? -v : v;
   endfunction
endpackage

// File: rtl/MULTU.sv
// MULTU: combinational 32x32 unsigned array multiplier; operands are held by the caller for a multicycle window.
module MULTU (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] z
);
   assign z = {32'b0, a} * {32'b0, b};
   a_stable: assert property (@(posedge clk) disable iff (reset) $stable(a) && $stable(b) |-> $stable(z));
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multicycle HI/LO multiply controller with MFHI/MFLO stall generation.
// Define MDU_SIGNED_EN to make op=MULT signed (magnitude operands plus 64-bit negate); otherwise MULT runs unsigned.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MUL_LAT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        rd_hilo,
   output logic        busy,
   output logic        done,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_lat_chk
      $error("mdu_ctrl: MUL_LAT out of range");
   end
   mdu_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0] opa_q, opa_d, opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
   logic done_q, done_d;
   logic [63:0] z, result;
`ifdef MDU_SIGNED_EN
   logic neg_q, neg_d, sgn;
   assign sgn    = op == MDU_MULT;
   assign result = neg_q ? ~z + 64'd1 : z;
`else
   assign result = z;
`endif
   MULTU u_mul (.clk(clk), .reset(~reset), .a(opa_q), .b(opb_q), .z(z));
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
`ifdef MDU_SIGNED_EN
      neg_d   = neg_q;
`endif
      if (state_q == MDU_IDLE && start) begin
         if (!op[1]) begin
            state_d = MDU_CALC;
            cnt_d   = CNT_W'(MUL_LAT);
`ifdef MDU_SIGNED_EN
            opa_d   = sgn ? mag(a) : a;
            opb_d   = sgn ? mag(b) : b;
            neg_d   = sgn & (a[31] ^ b[31]);
`else
            opa_d   = a;
            opb_d   = b;
`endif
         end else if (op == MDU_MTLO) lo_d = a;
         else hi_d = a;
      end else if (state_q == MDU_CALC) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            {hi_d, lo_d} = result;
            done_d       = 1'b1;
            state_d      = MDU_IDLE;
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= MDU_IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end
`ifdef MDU_SIGNED_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) neg_q <= 1'b0;
      else neg_q <= neg_d;
   end
`endif
   assign busy  = state_q == MDU_CALC;
   assign done  = done_q;
   assign stall = rd_hilo & busy;
   assign hi    = hi_q;
   assign lo    = lo_q;
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply-unit controller for the 54-instruction CPU. It accepts MULTU/MULT/MTHI/MTLO requests from the execute stage and registers operands. It holds them stable on the combinational 32x32 unsigned array multiplier for a fixed multicycle window, then captures the 64-bit product into the architectural HI/LO registers. It also generates the pipeline stall for MFHI/MFLO issued while a multiply is in flight.

## Interface
Parameters:
- MUL_LAT, 4: cycles operands are held on the multiplier before capture (multicycle path budget); legal range 1..15.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request valid for one cycle.
- op  input  2  request type: 00 MULTU, 01 MULT, 10 MTHI, 11 MTLO.
- a  input  32  rs operand; multiplicand, or data for MTHI/MTLO.
- b  input  32  rt operand, multiplier.
- rd_hilo  input  1  an MFHI/MFLO is in the execute stage.
- busy  output  1  multiply in flight.
- done  output  1  one-cycle pulse when HI/LO takes a product.
- stall  output  1  combinational `rd_hilo & busy`.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- FSM has two states. IDLE (busy=0) and CALC (busy=1). The state, counter, operand registers, hi, lo and done are all flops.
- IDLE, with start and op=00 or 01:
  - latch operand registers opa and opb;
  - load cnt=MUL_LAT;
  - go to CALC.
- IDLE, with start and op=10: hi<=a, lo unchanged, no done pulse. With start and op=11: lo<=a, hi unchanged.
- CALC, each edge: cnt<=cnt-1. At the edge where cnt==1:
  - {hi,lo}<=result;
  - done<=1 for one cycle;
  - go to IDLE.
- Unsigned result is the multiplier output on opa x opb, full 64 bits with no truncation.
- Signed handling (MULT, see Configuration):
  - opa and opb hold the magnitudes |a| and |b|; 0x80000000 maps to magnitude 0x80000000.
  - A flop neg is set to a[31]^b[31].
  - result = neg ? (~z+1) : z, computed at 64 bits.
- Any start (any op) while busy=1 is ignored and not queued. This includes the capture edge itself, because the state is still CALC at that edge. The issuing stage is responsible for not issuing.
- a and b may change freely after the accept edge. Only opa and opb drive the multiplier.
- Reset asserted at any time, including mid-CALC:
  - the current operation is dropped;
  - state=IDLE, cnt=0, opa=opb=0, neg=0;
  - hi=0, lo=0, busy=0, done=0.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, stall=0.
- Let E0 be the edge that accepts a multiply. busy is 1 for the cycles after E0 through E_MUL_LAT. hi/lo hold the new value, and done=1, in the cycle after E_MUL_LAT.
- Minimum spacing between accepted multiplies is MUL_LAT+1 cycles. A start in the done cycle is accepted.
- A MTHI/MTLO is visible on hi/lo one cycle after its accept edge.
- stall is combinational and has no latency. It drops in the done cycle, so an MFHI issued then reads the new product.
- MUL_LAT=1 gives busy for exactly one cycle.

## Configuration
- MDU_SIGNED_EN defined:
  - op=01 performs the signed multiply with the magnitude/negate path above;
  - the neg flop and 64-bit negator are present.
- Macro undefined:
  - op=01 is executed exactly as op=00 (unsigned);
  - no neg flop and no negator logic; opa=a and opb=b.

## Structure
- Shared package mdu_pkg holds:
  - op encodings MDU_MULTU=2'b00, MDU_MULT=2'b01, MDU_MTHI=2'b10, MDU_MTLO=2'b11;
  - state encodings MDU_IDLE and MDU_CALC;
  - the MUL_LAT legal-range constants.
- One sub-module, the team's existing unsigned array multiplier MULTU, instantiated once:
  - clk tied through;
  - its active-high reset driven by ~reset;
  - operands driven from opa and opb.
- All control (FSM, counter, sign handling, HI/LO) lives in mdu_ctrl.

## Test plan
- MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF, MUL_LAT=4 -> busy high for 4 cycles, then done pulse with hi=0xFFFFFFFE, lo=0x00000001.
- MULT with a=0xFFFFFFFD, b=0x00000007:
  - with MDU_SIGNED_EN -> hi=0xFFFFFFFF, lo=0xFFFFFFEB;
  - without it -> hi=0x00000006, lo=0xFFFFFFEB.
- MULT with a=0x80000000, b=0x80000000 (MDU_SIGNED_EN) -> hi=0x40000000, lo=0x00000000. MULT with a=0x80000000, b=0x00000001 -> hi=0xFFFFFFFF, lo=0x80000000.
- MTLO a=0x00001234 in IDLE with hi=0xAAAAAAAA -> next cycle lo=0x00001234, hi unchanged, no done. A MTHI or second multiply issued mid-CALC -> ignored, hi/lo reflect only the first product. rd_hilo=1 during CALC -> stall=1, and stall=0 in the done cycle.
- Reset pulsed low for one cycle at cnt=2 of a MULTU 5x7 -> hi=lo=0 and busy=0 immediately, no done pulse afterward. A new MULTU 5x7 then gives lo=0x00000023.
- Back-to-back: a second start held high through the done cycle -> accepted at the done-cycle edge, and its done arrives exactly MUL_LAT+1 cycles after the first done.
